data_memory_lsu: RTL and testbench

- Parametrised byte-addressable data memory for the MIPS datapath; successor to the word-indexed data memory.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads and misalignment detection.
- Read latency is configurable, and a ready/valid handshake lets the MEM stage stall on outstanding loads.
- Sits between the ALU result / rt operand and the writeback mux.

---
 rtl/data_memory_lsu.sv | 236 +++++++++++++++++++++++
 tb/tb_data_memory_lsu.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_lsu.sv
// -----------------------------------------------------------------------------
// data_memory_lsu
//   Byte-addressable data memory with load/store unit for the MIPS datapath.
//   Supports byte / halfword / word loads and stores, sign or zero extension
//   on loads, misalignment detection, a configurable read latency and a
//   ready/valid handshake so the MEM stage can stall on outstanding loads.
//
//   Optional feature macro: DMEM_PARITY_EN
//     defined   : one even-parity bit per byte, checked on loads (parity_err)
//     undefined : no parity storage, parity_err is held at 0
//
// Parameters
//   ADDR_WIDTH   byte-address bits decoded; depth = 2**ADDR_WIDTH bytes
//   READ_LATENCY cycles from load acceptance to rvalid (1..4)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          request valid, accepted when req && ready
//   we           1 = store, 0 = load
//   size         00 byte, 01 half, 10 word, 11 treated as word
//   unsigned_ld  1 = zero-extend load, 0 = sign-extend
//   addr         byte address (upper bits ignored, address wraps)
//   wdata        right-justified store data
//   ready        block can accept a request this cycle
//   rvalid       one-cycle load response pulse
//   rdata        extended load result, held until the next rvalid
//   misalign_err one-cycle misaligned-access pulse
//   parity_err   parity mismatch on the rvalid cycle (parity build only)
// -----------------------------------------------------------------------------
module data_memory_lsu #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        parity_err
);

  localparam int unsigned IW    = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
  localparam int unsigned WORDS = 1 << (ADDR_WIDTH - 2);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t                 state;
  logic [2:0]             cnt;
  logic [ADDR_WIDTH-1:0]  cap_addr;
  logic [1:0]             cap_size;
  logic                   cap_uns;

  logic [31:0]            mem [WORDS];

  logic [ADDR_WIDTH-1:0]  acc_addr;
  logic [1:0]             acc_size;
  logic                   acc_uns;
  logic [1:0]             lane;
  logic [IW-1:0]          acc_word;
  logic [31:0]            rd_word;
  logic                   is_word;
  logic                   is_half;
  logic                   mis;
  logic [3:0]             lane_mask;
  logic [7:0]             sel_byte;
  logic [15:0]            sel_half;
  logic [31:0]            ld_ext;
  logic [31:0]            st_data;
  logic                   accept;
  logic                   st_en;
  logic                   issue;
  logic                   perr_now;

  logic                   unused_hi;
  assign unused_hi = ^addr[31:ADDR_WIDTH];

  function automatic logic [IW-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] shifted;
    shifted = a >> 2;
    return shifted[IW-1:0];
  endfunction

  // The access being serviced: live inputs while idle, captured request
  // while waiting. ready is only high in IDLE, so stores always use the
  // live path and loads read memory on their final latency cycle.
  always_comb begin
    if (state == RD_WAIT) begin
      acc_addr = cap_addr;
      acc_size = cap_size;
      acc_uns  = cap_uns;
    end else begin
      acc_addr = addr[ADDR_WIDTH-1:0];
      acc_size = size;
      acc_uns  = unsigned_ld;
    end
  end

  always_comb begin
    lane     = acc_addr[1:0];
    acc_word = word_index(acc_addr);
    rd_word  = mem[acc_word];
    is_word  = acc_size[1];
    is_half  = (acc_size == 2'b01);

    mis = 1'b0;
    if (is_word)      mis = (lane != 2'b00);
    else if (is_half) mis = lane[0];

    if (is_word)      lane_mask = 4'b1111;
    else if (is_half) lane_mask = lane[1] ? 4'b1100 : 4'b0011;
    else              lane_mask = 4'b0001 << lane;

    case (lane)
      2'd0:    sel_byte = rd_word[7:0];
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    if (is_word)
      ld_ext = rd_word;
    else if (is_half)
      ld_ext = acc_uns ? {16'h0000, sel_half} : {{16{sel_half[15]}}, sel_half};
    else
      ld_ext = acc_uns ? {24'h000000, sel_byte} : {{24{sel_byte[7]}}, sel_byte};

    // Store data replicated across lanes; lane_mask picks the live ones.
    if (is_word)      st_data = wdata;
    else if (is_half) st_data = {2{wdata[15:0]}};
    else              st_data = {4{wdata[7:0]}};
  end

  always_comb begin
    accept = req && ready;
    // rst_n gates the write because ready reads 1 while reset is held.
    st_en  = rst_n && accept && we && !mis;
    issue  = ((state == IDLE) && accept && !we && (READ_LATENCY == 1)) ||
             ((state == RD_WAIT) && (cnt == 3'd1));
  end

  always_ff @(posedge clk) begin
    if (st_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lane_mask[b]) mem[acc_word][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par [WORDS];

  always_ff @(posedge clk) begin
    if (st_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lane_mask[b]) par[acc_word][b] <= ^st_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    perr_now = 1'b0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (lane_mask[b] && (par[acc_word][b] != ^rd_word[8*b +: 8])) perr_now = 1'b1;
    end
    if (mis) perr_now = 1'b0;
  end
`else
  assign perr_now = 1'b0;
`endif

  // Counter holds READ_LATENCY-1 on entry to RD_WAIT and the response is
  // issued on the edge where it would step from 1 to 0, giving exactly
  // READ_LATENCY cycles from acceptance to rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ready        <= 1'b1;
      rvalid       <= 1'b0;
      rdata        <= '0;
      misalign_err <= 1'b0;
      parity_err   <= 1'b0;
      cap_addr     <= '0;
      cap_size     <= '0;
      cap_uns      <= 1'b0;
    end else begin
      rvalid       <= 1'b0;
      misalign_err <= 1'b0;
      parity_err   <= 1'b0;

      if (issue) begin
        rvalid       <= 1'b1;
        misalign_err <= mis;
        rdata        <= mis ? '0 : ld_ext;
        parity_err   <= perr_now;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (we) begin
              misalign_err <= mis;
            end else if (READ_LATENCY > 1) begin
              cap_addr <= addr[ADDR_WIDTH-1:0];
              cap_size <= size;
              cap_uns  <= unsigned_ld;
              cnt      <= 3'(READ_LATENCY - 1);
              ready    <= 1'b0;
              state    <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt == 3'd1) begin
            cnt   <= '0;
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// -----------------------------------------------------------------------------
// tb_data_memory_lsu
//   Two instances share one stimulus stream: instance 0 with READ_LATENCY=1,
//   instance 1 with READ_LATENCY=3. A byte-array reference model predicts
//   ready/rvalid/rdata/misalign_err/parity_err per instance every cycle;
//   a short list of literal load results pins the model.
// -----------------------------------------------------------------------------
module tb_data_memory_lsu;

  localparam int unsigned AW = 10;
  localparam int unsigned NB = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [1:0]  ready;
  logic [1:0]  rvalid;
  logic [1:0]  mis;
  logic [1:0]  perr;
  logic [31:0] rdata [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    data_memory_lsu #(
      .ADDR_WIDTH  (AW),
      .READ_LATENCY((gi == 0) ? 1 : 3)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .we          (we),
      .size        (size),
      .unsigned_ld (unsigned_ld),
      .addr        (addr),
      .wdata       (wdata),
      .ready       (ready[gi]),
      .rvalid      (rvalid[gi]),
      .rdata       (rdata[gi]),
      .misalign_err(mis[gi]),
      .parity_err  (perr[gi])
    );
  end

  // ---------------- reference model ----------------
  logic [7:0]    mm [2][NB];
  logic [NB-1:0] pflip [2] = '{default: '0};
  logic [1:0]    e_ready, e_rvalid, e_mis, e_perr;
  logic [31:0]   e_rdata [2];
  logic [1:0]    p_valid, p_mis, p_par;
  logic [31:0]   p_data [2];
  int unsigned   p_due [2];
  int unsigned   cyc = 0;
  logic          live = 1'b0;

  logic          bd_stb = 1'b0;
  int unsigned   bd_addr = 0;

  int checks = 0;
  int failures = 0;

  logic [31:0] lit_data [2][32];
  logic        lit_mis  [2][32];
  logic        lit_par  [2][32];
  int unsigned lit_wr [2] = '{0, 0};
  int unsigned lit_rd [2] = '{0, 0};
  logic        done = 1'b0;

  function automatic int unsigned lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int unsigned nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic misaligned(input logic [1:0] s, input int unsigned a);
    if (s[1]) return (a % 4) != 0;
    if (s == 2'b01) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(input int i, input int unsigned a,
                                           input logic [1:0] s, input logic u);
    int unsigned n;
    logic [31:0] v;
    n = nbytes(s);
    v = '0;
    for (int unsigned b = 0; b < n; b++) v = v | (32'(mm[i][a + b]) << (8 * b));
    if (n == 1 && !u && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && !u && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic flip_hit(input int i, input int unsigned a, input logic [1:0] s);
    logic hit;
    hit = 1'b0;
    for (int unsigned b = 0; b < nbytes(s); b++) hit = hit | pflip[i][a + b];
    return hit;
  endfunction

  always @(posedge clk) begin
    live <= 1'b1;
    cyc  <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      logic        acc, m, pv, pm, pp, smis, resp;
      logic [31:0] pd;
      int unsigned due, a;
      if (!rst_n) begin
        p_valid[i]  <= 1'b0;
        e_ready[i]  <= 1'b1;
        e_rvalid[i] <= 1'b0;
        e_rdata[i]  <= '0;
        e_mis[i]    <= 1'b0;
        e_perr[i]   <= 1'b0;
      end else begin
        pv = p_valid[i]; pd = p_data[i]; pm = p_mis[i]; pp = p_par[i]; due = p_due[i];
        smis = 1'b0;
        acc  = req && e_ready[i];
        a    = addr % NB;
        m    = misaligned(size, a);
        if (bd_stb) pflip[i][bd_addr] <= 1'b1;
        if (acc && we) begin
          if (m) smis = 1'b1;
          else begin
            for (int unsigned b = 0; b < nbytes(size); b++) begin
              mm[i][a + b]    <= wdata[8*b +: 8];
              pflip[i][a + b] <= 1'b0;
            end
          end
        end
        if (acc && !we) begin
          pv  = 1'b1;
          due = cyc + lat(i) - 1;
          pm  = m;
          pd  = m ? 32'h0 : load_val(i, a, size, unsigned_ld);
          pp  = !m && flip_hit(i, a, size);
        end
        resp = pv && (due == cyc);
        if (resp) begin
          e_rdata[i] <= pd;
          pv = 1'b0;
        end
        e_rvalid[i] <= resp;
        e_mis[i]    <= smis || (resp && pm);
        e_perr[i]   <= resp && pp;
        e_ready[i]  <= !pv;
        p_valid[i]  <= pv;
        p_data[i]   <= pd;
        p_mis[i]    <= pm;
        p_par[i]    <= pp;
        p_due[i]    <= due;
      end
    end
  end

  // ---------------- compare process ----------------
  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%h expected=%h t=%0t", name, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < 2; i++) begin
        chk("ready",        i, 32'(ready[i]),  32'(e_ready[i]));
        chk("rvalid",       i, 32'(rvalid[i]), 32'(e_rvalid[i]));
        chk("misalign_err", i, 32'(mis[i]),    32'(e_mis[i]));
        chk("parity_err",   i, 32'(perr[i]),   32'(e_perr[i]));
        chk("rdata",        i, rdata[i],       e_rdata[i]);
        if (rvalid[i] && lit_rd[i] != lit_wr[i]) begin
          chk("lit_rdata",    i, rdata[i],     lit_data[i][lit_rd[i] % 32]);
          chk("lit_misalign", i, 32'(mis[i]),  32'(lit_mis[i][lit_rd[i] % 32]));
          chk("lit_parity",   i, 32'(perr[i]), 32'(lit_par[i][lit_rd[i] % 32]));
          lit_rd[i]++;
        end
      end
    end
    if (done) begin
      for (int i = 0; i < 2; i++) chk("lit_drain", i, lit_rd[i], lit_wr[i]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic expect_lit(input int i, input logic [31:0] d, input logic m, input logic p);
    lit_data[i][lit_wr[i] % 32] = d;
    lit_mis[i][lit_wr[i] % 32]  = m;
    lit_par[i][lit_wr[i] % 32]  = p;
    lit_wr[i]++;
  endtask

  task automatic expect_both(input logic [31:0] d, input logic m);
    expect_lit(0, d, m, 1'b0);
    expect_lit(1, d, m, 1'b0);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20 && ready != 2'b11; n++) @(negedge clk);
  endtask

  task automatic op(input logic w, input logic [1:0] s, input logic u,
                    input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    req = 1'b1; we = w; size = s; unsigned_ld = u; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    for (int unsigned w = 0; w < NB / 4; w++) op(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom);

    // word store / load, latency 1 and 3
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    expect_both(32'hDEAD_BEEF, 1'b0);
    op(1'b0, 2'b10, 1'b0, 32'h10, '0);

    // byte store, signed / unsigned byte loads, word readback
    op(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0080);
    expect_both(32'hFFFF_FF80, 1'b0);
    op(1'b0, 2'b00, 1'b0, 32'h11, '0);
    expect_both(32'h0000_0080, 1'b0);
    op(1'b0, 2'b00, 1'b1, 32'h11, '0);
    expect_both(32'hDEAD_80EF, 1'b0);
    op(1'b0, 2'b10, 1'b0, 32'h10, '0);

    // misaligned half store (no write), misaligned word load
    op(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000_1234);
    expect_both(32'hDEAD_80EF, 1'b0);
    op(1'b0, 2'b10, 1'b0, 32'h10, '0);
    expect_both(32'h0000_0000, 1'b1);
    op(1'b0, 2'b10, 1'b0, 32'h12, '0);
    // size=11 behaves as word; halfword signed load of upper half
    expect_both(32'hDEAD_80EF, 1'b0);
    op(1'b0, 2'b11, 1'b0, 32'h10, '0);
    expect_both(32'hFFFF_DEAD, 1'b0);
    op(1'b0, 2'b01, 1'b0, 32'h12, '0);

    // request held through the latency-3 stall
    op(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFE_F00D);
    wait_idle();
    expect_lit(0, 32'hDEAD_80EF, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) expect_lit(0, 32'hCAFE_F00D, 1'b0, 1'b0);
    expect_lit(1, 32'hDEAD_80EF, 1'b0, 1'b0);
    expect_lit(1, 32'hCAFE_F00D, 1'b0, 1'b0);
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10;
    @(negedge clk);
    addr = 32'h14;
    repeat (3) @(negedge clk);
    req = 1'b0;

    // reset one cycle after a latency-3 load is accepted
    wait_idle();
    expect_lit(0, 32'hDEAD_80EF, 1'b0, 1'b0);
    op(1'b0, 2'b10, 1'b0, 32'h10, '0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    expect_both(32'hDEAD_80EF, 1'b0);
    op(1'b0, 2'b10, 1'b0, 32'h10, '0);

`ifdef DMEM_PARITY_EN
    op(1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_00FF);
    g_dut[0].u_dut.par[8][0] = ~g_dut[0].u_dut.par[8][0];
    g_dut[1].u_dut.par[8][0] = ~g_dut[1].u_dut.par[8][0];
    bd_addr = 32'h20;
    bd_stb  = 1'b1;
    @(negedge clk);
    bd_stb  = 1'b0;
    expect_lit(0, 32'h0000_00FF, 1'b0, 1'b1);
    expect_lit(1, 32'h0000_00FF, 1'b0, 1'b1);
    op(1'b0, 2'b10, 1'b0, 32'h20, '0);
`endif

    // randomized traffic, including address wrap and rare resets
    wait_idle();
    for (int n = 0; n < 2500; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      req         = ($urandom_range(0, 3) != 0);
      we          = $urandom_range(0, 1) != 0;
      size        = 2'($urandom_range(0, 3));
      unsigned_ld = $urandom_range(0, 1) != 0;
      ra          = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'b01) ra[0] = 1'b0;
        else if (size[1]) ra[1:0] = 2'b00;
      end
      addr  = ra;
      wdata = $urandom;
    end
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    done = 1'b1;
  end

endmodule
